// File: rtl/dec_out_mux_fifo.sv
// rtl/dec_out_mux_fifo.sv - channel select mux into an output FIFO with drop counting (optional MUX_FLUSH_ON_SEL_EN)
module dec_out_mux_fifo #(
  parameter int D_WIDTH    = 8,
  parameter int N_CH       = 3,
  parameter int SEL_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEL_W-1:0]              select,
  input  logic [N_CH*D_WIDTH-1:0]       data_i,
  input  logic [N_CH-1:0]               valid_i,
  output logic [D_WIDTH-1:0]            data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          drop_o,
  output logic [CNT_W-1:0]              drop_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;

  logic               sel_valid;
  logic [D_WIDTH-1:0] sel_data;
  logic               flush;
  logic               push;
  logic               pop;
  logic               full;
  logic               wr_en;
  logic               drop_ev;

  // Pick the selected channel; out-of-range select leaves sel_valid low
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (select == SEL_W'(k)) begin
        sel_valid = valid_i[k];
        sel_data  = data_i[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

`ifdef MUX_FLUSH_ON_SEL_EN
  logic [SEL_W-1:0] sel_q;

  // Track the previous select; its reset value is whatever select is during reset
  always_ff @(posedge clk) begin
    sel_q <= select;
  end

  assign flush = (select != sel_q);
`else
  assign flush = 1'b0;
`endif

  assign push    = sel_valid && !flush;
  assign pop     = (level != '0) && ready_i && !flush;
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign wr_en   = push && (!full || pop);
  assign drop_ev = push && full && !pop;

  // Pointer, occupancy and drop bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_o     <= 1'b0;
      drop_cnt_o <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      drop_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !wr_en) begin
        level <= level - 1'b1;
      end
      drop_o <= drop_ev;
      if (drop_ev && (drop_cnt_o != {CNT_W{1'b1}})) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= sel_data;
    end
  end

  assign valid_o = (level != '0);
  assign data_o  = valid_o ? mem[rd_ptr] : '0;
  assign level_o = level;

endmodule

// File: tb/tb_dec_out_mux_fifo.sv
// tb/tb_dec_out_mux_fifo.sv - self-checking bench for dec_out_mux_fifo
module tb_dec_out_mux_fifo;

  localparam int D_WIDTH    = 8;
  localparam int N_CH       = 3;
  localparam int SEL_W      = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                        clk;
  logic                        rst;
  logic [SEL_W-1:0]            select;
  logic [N_CH*D_WIDTH-1:0]     data_i;
  logic [N_CH-1:0]             valid_i;
  logic [D_WIDTH-1:0]          data_o;
  logic                        valid_o;
  logic                        ready_i;
  logic                        drop_o;
  logic [CNT_W-1:0]            drop_cnt_o;
  logic [$clog2(FIFO_DEPTH):0] level_o;

  int tests;
  int fails;

  dec_out_mux_fifo #(
    .D_WIDTH(D_WIDTH), .N_CH(N_CH), .SEL_W(SEL_W),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .select(select), .data_i(data_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .drop_o(drop_o),
    .drop_cnt_o(drop_cnt_o), .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue plus a drop flag and counter
  logic [7:0] mq[$];
  logic [7:0] out_log[$];
  bit         m_drop;
  int         m_cnt;
  logic [SEL_W-1:0] m_selq;
  bit         model_live;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    logic [7:0] w;
    if (rst) begin
      mq.delete();
      m_drop = 0;
      m_cnt = 0;
      m_selq = select;
      model_live = 1;
    end else begin
`ifdef MUX_FLUSH_ON_SEL_EN
      if (select != m_selq) begin
        mq.delete();
        m_drop = 0;
        m_selq = select;
      end else begin
`else
      begin
`endif
        do_push = 0;
        w = 8'h00;
        if (int'(select) < N_CH) begin
          do_push = valid_i[select];
          w = data_i[int'(select)*D_WIDTH +: D_WIDTH];
        end
        do_pop = (mq.size() != 0) && ready_i;
        m_drop = 0;
        if (do_pop) out_log.push_back(mq.pop_front());
        if (do_push) begin
          if (mq.size() < FIFO_DEPTH) mq.push_back(w);
          else begin
            m_drop = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_live && !rst) begin
      chk("m_valid", 32'(valid_o), 32'(mq.size() != 0));
      chk("m_data", 32'(data_o), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("m_level", 32'(level_o), 32'(mq.size()));
      chk("m_drop", 32'(drop_o), 32'(m_drop));
      chk("m_cnt", 32'(drop_cnt_o), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [SEL_W-1:0] s, input logic [N_CH-1:0] v,
                       input logic [7:0] d, input logic r);
    select  = s;
    valid_i = v;
    data_i  = {N_CH{d}};
    ready_i = r;
    step();
  endtask

  int drops_seen;
  logic [7:0] exp_log[$];

  initial begin
    tests = 0; fails = 0; model_live = 0; drops_seen = 0;
    rst = 1; select = 2'd1; valid_i = 3'b111; data_i = {N_CH{8'h5A}}; ready_i = 0;
    // 1: reset with traffic
    step(); step();
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_cnt", 32'(drop_cnt_o), 32'h0);
    rst = 0;
    // 2: single word on channel 1
    drive(2'd1, 3'b010, 8'h41, 1'b1);
    chk("t2_valid", 32'(valid_o), 32'h1);
    chk("t2_data", 32'(data_o), 32'h41);
    drive(2'd1, 3'b000, 8'h00, 1'b1);
    chk("t2_valid_off", 32'(valid_o), 32'h0);
    chk("t2_data_off", 32'(data_o), 32'h0);
    // 3: overfill from channel 0
    drive(2'd0, 3'b000, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(2'd0, 3'b001, 8'(8'h10 + i), 1'b0);
      drops_seen += int'(drop_o);
    end
    drive(2'd0, 3'b000, 8'h00, 1'b0);
    drops_seen += int'(drop_o);
    chk("t3_level", 32'(level_o), 32'h4);
    chk("t3_drop_pulses", 32'(drops_seen), 32'h2);
    chk("t3_cnt", 32'(drop_cnt_o), 32'h2);
    // 4: full with simultaneous pop and push
    drive(2'd0, 3'b001, 8'hAA, 1'b1);
    chk("t4_level", 32'(level_o), 32'h4);
    chk("t4_drop", 32'(drop_o), 32'h0);
    for (int i = 0; i < 4; i++) drive(2'd0, 3'b000, 8'h00, 1'b1);
    chk("t4_empty", 32'(valid_o), 32'h0);
    exp_log = '{8'h41, 8'h10, 8'h11, 8'h12, 8'h13, 8'hAA};
    chk("t4_log_len", 32'(out_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      chk("t4_order", 32'(out_log[i]), 32'(exp_log[i]));
    // 5: select out of range
    drive(2'd3, 3'b111, 8'h77, 1'b0);
    drive(2'd3, 3'b111, 8'h78, 1'b0);
    chk("t5_level", 32'(level_o), 32'h0);
    chk("t5_cnt", 32'(drop_cnt_o), 32'h2);
    // 6: channel switch with words queued
    drive(2'd0, 3'b000, 8'h00, 1'b0);
    drive(2'd0, 3'b001, 8'h20, 1'b0);
    drive(2'd0, 3'b001, 8'h21, 1'b0);
    chk("t6_level_pre", 32'(level_o), 32'h2);
    drive(2'd2, 3'b100, 8'h30, 1'b0);
`ifdef MUX_FLUSH_ON_SEL_EN
    chk("t6_flush_valid", 32'(valid_o), 32'h0);
    chk("t6_flush_level", 32'(level_o), 32'h0);
    for (int i = 0; i < 3; i++) drive(2'd2, 3'b000, 8'h00, 1'b1);
    chk("t6_log_len", 32'(out_log.size()), 32'h6);
`else
    chk("t6_level", 32'(level_o), 32'h3);
    for (int i = 0; i < 3; i++) drive(2'd2, 3'b000, 8'h00, 1'b1);
    chk("t6_log_len", 32'(out_log.size()), 32'h9);
    if (out_log.size() == 9) begin
      chk("t6_w0", 32'(out_log[6]), 32'h20);
      chk("t6_w1", 32'(out_log[7]), 32'h21);
      chk("t6_w2", 32'(out_log[8]), 32'h30);
    end
`endif
    // Drop counter saturation
    drive(2'd0, 3'b000, 8'h00, 1'b0);
    for (int i = 0; i < FIFO_DEPTH + CNT_MAX + 4; i++) drive(2'd0, 3'b001, 8'(i), 1'b0);
    chk("sat_cnt", 32'(drop_cnt_o), 32'(CNT_MAX));
    chk("sat_drop", 32'(drop_o), 32'h1);
    // Reset mid-burst
    rst = 1;
    drive(2'd0, 3'b001, 8'hEE, 1'b0);
    rst = 0;
    chk("mid_rst_level", 32'(level_o), 32'h0);
    chk("mid_rst_cnt", 32'(drop_cnt_o), 32'h0);
    chk("mid_rst_valid", 32'(valid_o), 32'h0);
    drive(2'd0, 3'b000, 8'h00, 1'b0);
    chk("post_rst_level", 32'(level_o), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
